// File: rtl/pool_sched.sv
// Address/tag scheduler for a 3x3 pooling datapath. It walks the output map in
// raster order and issues nine SRAM reads per window. A result tag follows each
// window through the datapath latency.
module pool_sched #(
  parameter int unsigned AW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [5:0]    cfg_h,
  input  logic [5:0]    cfg_w,
  input  logic [1:0]    cfg_stride,
  input  logic [AW-1:0] base_addr,
  input  logic          res_rdy,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic          pool_in_vld,
  output logic          tag_vld,
  output logic [5:0]    out_row,
  output logic [5:0]    out_col,
  output logic          busy,
  output logic          done,
  output logic          cfg_err
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_RDY = 2'd1;
  localparam logic [1:0] ST_ISSUE    = 2'd2;
  localparam logic [1:0] ST_DRAIN    = 2'd3;

  logic [1:0]    state_q;
  logic [5:0]    h_q, w_q;
  logic [1:0]    s_q;
  logic [AW-1:0] win_base_q;  // base + r0*W: start of the window's top row
  logic [AW-1:0] row_ptr_q;   // base + (r0+kr)*W: start of the row being read
  logic [5:0]    r0_q, c0_q;
  logic [5:0]    orow_q, ocol_q;
  logic [1:0]    kr_q, kc_q;
  logic          rd_en_q;
  logic [AW-1:0] rd_addr_q;
  logic          done_q, cfg_err_q;
  // Tag stage aligned with the window's 9th pool_in_vld
  logic          tag1_vld_q;
  logic [5:0]    tag1_row_q, tag1_col_q;
  logic          pool_vld_q, tag_vld_q;
  logic [5:0]    out_row_q, out_col_q;

  logic          cfg_ok;
  logic [AW-1:0] w_ext, sw;
  logic [7:0]    c0_step, r0_step;
  logic          more_col, more_row, more_win, last_read;
  logic [5:0]    nxt_c0, nxt_r0, nxt_orow, nxt_ocol;
  logic [AW-1:0] nxt_win_base, nxt_first_addr;

  // Window stepping: next origin, stride*W via shift-add, and last-window tests
  always_comb begin
    cfg_ok    = (cfg_h >= 6'd3) && (cfg_w >= 6'd3) && (cfg_stride != 2'd0);
    w_ext     = AW'(w_q);
    sw        = w_ext;
    case (s_q)
      2'd2:    sw = w_ext << 1;
      2'd3:    sw = (w_ext << 1) + w_ext;
      default: sw = w_ext;
    endcase
    c0_step   = 8'(c0_q) + 8'(s_q);
    r0_step   = 8'(r0_q) + 8'(s_q);
    // A further window fits only if its origin plus 3 stays inside the map
    more_col  = (c0_step + 8'd3) <= 8'(w_q);
    more_row  = (r0_step + 8'd3) <= 8'(h_q);
    more_win  = more_col || more_row;
    last_read = (kr_q == 2'd2) && (kc_q == 2'd2);
    if (more_col) begin
      nxt_c0       = c0_step[5:0];
      nxt_r0       = r0_q;
      nxt_ocol     = ocol_q + 6'd1;
      nxt_orow     = orow_q;
      nxt_win_base = win_base_q;
    end else begin
      nxt_c0       = 6'd0;
      nxt_r0       = r0_step[5:0];
      nxt_ocol     = 6'd0;
      nxt_orow     = orow_q + 6'd1;
      nxt_win_base = win_base_q + sw;
    end
    nxt_first_addr = nxt_win_base + AW'(nxt_c0);
  end

  // Control FSM, window counters and read address generation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      h_q        <= '0;
      w_q        <= '0;
      s_q        <= '0;
      win_base_q <= '0;
      row_ptr_q  <= '0;
      r0_q       <= '0;
      c0_q       <= '0;
      orow_q     <= '0;
      ocol_q     <= '0;
      kr_q       <= '0;
      kc_q       <= '0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
      tag1_vld_q <= 1'b0;
      tag1_row_q <= '0;
      tag1_col_q <= '0;
    end else begin
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
      tag1_vld_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              h_q        <= cfg_h;
              w_q        <= cfg_w;
              s_q        <= cfg_stride;
              win_base_q <= base_addr;
              row_ptr_q  <= base_addr;
              r0_q       <= '0;
              c0_q       <= '0;
              orow_q     <= '0;
              ocol_q     <= '0;
              kr_q       <= '0;
              kc_q       <= '0;
              state_q    <= ST_WAIT_RDY;
            end else begin
              done_q    <= 1'b1;
              cfg_err_q <= 1'b1;
            end
          end
        end
        ST_WAIT_RDY: begin
          if (res_rdy) begin
            rd_en_q   <= 1'b1;
            rd_addr_q <= win_base_q + AW'(c0_q);
            row_ptr_q <= win_base_q;
            kr_q      <= '0;
            kc_q      <= '0;
            state_q   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!last_read) begin
            if (kc_q != 2'd2) begin
              kc_q      <= kc_q + 2'd1;
              rd_addr_q <= rd_addr_q + AW'(1);
            end else begin
              kc_q      <= '0;
              kr_q      <= kr_q + 2'd1;
              row_ptr_q <= row_ptr_q + w_ext;
              rd_addr_q <= row_ptr_q + w_ext + AW'(c0_q);
            end
          end else begin
            tag1_vld_q <= 1'b1;
            tag1_row_q <= orow_q;
            tag1_col_q <= ocol_q;
            kr_q       <= '0;
            kc_q       <= '0;
            if (more_win) begin
              c0_q       <= nxt_c0;
              r0_q       <= nxt_r0;
              ocol_q     <= nxt_ocol;
              orow_q     <= nxt_orow;
              win_base_q <= nxt_win_base;
              row_ptr_q  <= nxt_win_base;
              // res_rdy only matters here, at the window boundary
              if (res_rdy) begin
                rd_addr_q <= nxt_first_addr;
              end else begin
                rd_en_q <= 1'b0;
                state_q <= ST_WAIT_RDY;
              end
            end else begin
              rd_en_q <= 1'b0;
              state_q <= ST_DRAIN;
            end
          end
        end
        default: begin
          // Last window's 9th datum is in the datapath; finish with its tag
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Datapath-latency alignment of the read strobe and result tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pool_vld_q <= 1'b0;
      tag_vld_q  <= 1'b0;
      out_row_q  <= '0;
      out_col_q  <= '0;
    end else begin
      pool_vld_q <= rd_en_q;
      tag_vld_q  <= tag1_vld_q;
      if (tag1_vld_q) begin
        out_row_q <= tag1_row_q;
        out_col_q <= tag1_col_q;
      end
    end
  end

  assign rd_en       = rd_en_q;
  assign rd_addr     = rd_addr_q;
  assign pool_in_vld = pool_vld_q;
  assign tag_vld     = tag_vld_q;
  assign out_row     = out_row_q;
  assign out_col     = out_col_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_pool_sched.sv
// Bench for pool_sched: directed jobs plus random configurations, checked per
// cycle against a window-list model built from the output-map arithmetic.
module tb_pool_sched;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [5:0]    cfg_h, cfg_w;
  logic [1:0]    cfg_stride;
  logic [AW-1:0] base_addr;
  logic          res_rdy;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          pool_in_vld;
  logic          tag_vld;
  logic [5:0]    out_row, out_col;
  logic          busy, done, cfg_err;

  int n_tests = 0;
  int n_fail  = 0;

  pool_sched #(.AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cfg_h      (cfg_h),
    .cfg_w      (cfg_w),
    .cfg_stride (cfg_stride),
    .base_addr  (base_addr),
    .res_rdy    (res_rdy),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .pool_in_vld(pool_in_vld),
    .tag_vld    (tag_vld),
    .out_row    (out_row),
    .out_col    (out_col),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".rd_en"}, 32'(rd_en), 0);
    chk({tag, ".rd_addr"}, 32'(rd_addr), 0);
    chk({tag, ".pool_in_vld"}, 32'(pool_in_vld), 0);
    chk({tag, ".tag_vld"}, 32'(tag_vld), 0);
    chk({tag, ".out_row"}, 32'(out_row), 0);
    chk({tag, ".out_col"}, 32'(out_col), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".cfg_err"}, 32'(cfg_err), 0);
  endtask

  // mode 0: res_rdy always high; 1: random; 2: low for 20 cycles after window 2.
  // glitch_cyc >= 0 pulses start with another cfg mid-job.
  // rst_at >= 0 asserts reset while that read (0-based) is on the bus, then returns.
  task automatic run_job(input int h, input int w, input int s, input logic [AW-1:0] base,
                         input int mode, input int glitch_cyc, input int rst_at);
    logic [AW-1:0] ea[$];
    int tr[$], tc[$], due[$];
    int oh, ow, nreads, ridx, k, wins_done, hold, t;
    bit exp_rd, prev_rd, exp_tag, exp_done, fin, rdy, nxt;
    logic [AW-1:0] a;
    oh = (h - 3) / s + 1;
    ow = (w - 3) / s + 1;
    for (int r = 0; r < oh; r++) begin
      for (int c = 0; c < ow; c++) begin
        for (int kr = 0; kr < 3; kr++) begin
          for (int kc = 0; kc < 3; kc++) begin
            a = AW'(int'(base) + (r * s + kr) * w + c * s + kc);
            ea.push_back(a);
          end
        end
        tr.push_back(r);
        tc.push_back(c);
      end
    end
    nreads = ea.size();
    ridx = 0; k = 0; wins_done = 0; hold = 0; t = 0;
    exp_rd = 1'b0; prev_rd = 1'b0; fin = 1'b0;

    @(negedge clk);
    cfg_h = 6'(h); cfg_w = 6'(w); cfg_stride = 2'(s); base_addr = base; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!fin && t < 4000) begin
      chk("rd_en", 32'(rd_en), 32'(exp_rd));
      if (exp_rd) begin
        if (rd_en === 1'b1) chk("rd_addr", 32'(rd_addr), 32'(ea[ridx]));
        if (rst_at >= 0 && ridx == rst_at) begin
          rst_n = 1'b0;
          #1;
          chk_all_zero("mid_reset");
          return;
        end
        ridx++;
        k++;
        if (k == 9) begin
          due.push_back(t + 2);
          k = 0;
          wins_done++;
        end
      end
      chk("pool_in_vld", 32'(pool_in_vld), 32'(prev_rd));
      prev_rd = exp_rd;
      exp_tag = (due.size() > 0) && (due[0] == t);
      chk("tag_vld", 32'(tag_vld), 32'(exp_tag));
      if (exp_tag) begin
        void'(due.pop_front());
        chk("out_row", 32'(out_row), 32'(tr.pop_front()));
        chk("out_col", 32'(out_col), 32'(tc.pop_front()));
      end
      exp_done = exp_tag && (tr.size() == 0);
      chk("done", 32'(done), 32'(exp_done));
      chk("busy", 32'(busy), 32'(!exp_done));
      chk("cfg_err", 32'(cfg_err), 0);
      if (exp_done) fin = 1'b1;

      case (mode)
        0: rdy = 1'b1;
        1: rdy = 1'($urandom_range(0, 1));
        default: begin
          if (wins_done == 2 && hold < 20) begin
            rdy = 1'b0;
            hold++;
          end else begin
            rdy = 1'b1;
          end
        end
      endcase
      // Mid-window reads continue regardless of res_rdy; boundaries obey it
      if (exp_rd && k != 0) nxt = 1'b1;
      else if (ridx < nreads) nxt = rdy;
      else nxt = 1'b0;
      if (t == glitch_cyc) begin
        cfg_h = 6'd9; cfg_w = 6'd11; cfg_stride = 2'd3; base_addr = '0; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      res_rdy = rdy;
      exp_rd = nxt;
      t++;
      @(negedge clk);
    end
    start = 1'b0;
    if (!fin) chk("job_timeout", 0, 1);
    chk("reads_issued", 32'(ridx), 32'(nreads));
  endtask

  task automatic run_bad(input int h, input int w, input int s);
    @(negedge clk);
    cfg_h = 6'(h); cfg_w = 6'(w); cfg_stride = 2'(s); base_addr = 12'h3a0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("bad.done", 32'(done), 1);
    chk("bad.cfg_err", 32'(cfg_err), 1);
    chk("bad.busy", 32'(busy), 0);
    chk("bad.rd_en", 32'(rd_en), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bad.done_after", 32'(done), 0);
      chk("bad.cfg_err_after", 32'(cfg_err), 0);
      chk("bad.rd_en_after", 32'(rd_en), 0);
      chk("bad.busy_after", 32'(busy), 0);
    end
  endtask

  initial begin
    int rh, rw, rs, rm;
    rst_n = 1'b0; start = 1'b0; res_rdy = 1'b0;
    cfg_h = '0; cfg_w = '0; cfg_stride = '0; base_addr = '0;
    @(negedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("idle");

    run_job(3, 3, 1, 12'h100, 0, -1, -1);   // single window
    run_job(5, 5, 2, 12'h000, 0, -1, -1);   // 4 windows back-to-back
    run_job(4, 5, 1, 12'h7f0, 2, -1, -1);   // res_rdy held low after window 2
    run_job(6, 7, 1, 12'h020, 0, 15, -1);   // start mid-job ignored
    run_job(7, 9, 3, 12'hff8, 1, -1, -1);   // address wraps modulo 2^AW
    run_bad(6, 2, 1);
    run_bad(6, 6, 0);
    run_bad(2, 8, 2);

    // Reset during the 5th read of the second window
    run_job(5, 5, 1, 12'h040, 0, -1, 13);
    @(negedge clk);
    chk_all_zero("in_reset");
    rst_n = 1'b1;
    res_rdy = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("post_reset.rd_en", 32'(rd_en), 0);
      chk("post_reset.tag_vld", 32'(tag_vld), 0);
      chk("post_reset.done", 32'(done), 0);
    end
    run_job(5, 5, 1, 12'h040, 1, -1, -1);

    for (int j = 0; j < 8; j++) begin
      rh = $urandom_range(3, 12);
      rw = $urandom_range(3, 12);
      rs = $urandom_range(1, 3);
      rm = $urandom_range(0, 1);
      run_job(rh, rw, rs, AW'($urandom), rm, -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pool_sched.md
POOL_SCHED -- requirements
Module: pool_sched

Interface
REQ-001 SHALL have parameter AW, default 12, meaning feature-map SRAM address width.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  one-cycle request to pool one feature map; ignored while busy=1.
REQ-005 cfg_h, cfg_w  input  6 each  map height/width in pixels, latched when start is accepted.
REQ-006 cfg_stride  input  2  window stride 1..3, latched when start is accepted.
REQ-007 base_addr  input  AW  address of pixel (0,0), row-major; latched when start is accepted.
REQ-008 res_rdy  input  1  downstream can absorb one pooled result.
REQ-009 rd_en, rd_addr  output  1, AW  SRAM read strobe/address; read data returns one cycle later.
REQ-010 pool_in_vld  output  1  to the 3x3 pooling datapath; rd_en delayed one cycle, aligned with read data.
REQ-011 tag_vld, out_row, out_col  output  1, 6, 6  result tag; pulses with the datapath's result valid.
REQ-012 busy, done, cfg_err  output  1 each  job active / one-cycle job-end pulse / job rejected.

Function
REQ-013 Output map: OH=(H-3)/S+1 and OW=(W-3)/S+1 (integer division); windows are issued raster order, out_row outer, out_col inner.
REQ-014 Window (orow,ocol) origin r0=orow*S, c0=ocol*S; 9 reads in order kr=0..2 outer, kc=0..2 inner, addr=base+(r0+kr)*W+(c0+kc), computed modulo 2^AW from an incremental row-base register (no multiplier).
REQ-015 FSM states IDLE, WAIT_RDY, ISSUE, DRAIN.
REQ-016 IDLE: on start with legal cfg (H>=3, W>=3, S!=0) latch cfg, set busy=1, go WAIT_RDY.
REQ-017 IDLE: on start with illegal cfg, next cycle done=1 and cfg_err=1 for one cycle, busy stays 0, no reads.
REQ-018 WAIT_RDY: when res_rdy=1 go ISSUE; rd_en=1 with window's first address in the cycle after res_rdy sampled high.
REQ-019 ISSUE: rd_en=1 for exactly 9 consecutive cycles per window; never deasserted mid-window regardless of res_rdy.
REQ-020 At the 9th read: if more windows remain and res_rdy=1, next window's first read follows back-to-back; if more remain and res_rdy=0, go WAIT_RDY; if last window, go DRAIN.
REQ-021 res_rdy is sampled only at window boundaries (WAIT_RDY, or the 9th-read cycle).
REQ-022 tag_vld=1 for one cycle, one cycle after the window's 9th pool_in_vld, with out_row/out_col of that window.
REQ-023 DRAIN: done=1 for one cycle coincident with the last tag_vld; busy falls in the same cycle; go IDLE.
REQ-024 start while busy=1 SHALL be ignored with no change to latched cfg.
REQ-025 H=3 or W=3 yields a single row/column of windows; pixels beyond the last full window are never read.
REQ-026 A new start accepted in the cycle after done SHALL behave identically to a start from reset.

Reset
REQ-027 rst_n low SHALL asynchronously force state IDLE; rd_en, pool_in_vld, tag_vld, busy, done, cfg_err = 0; rd_addr, out_row, out_col, all counters and latched cfg = 0.
REQ-028 Reset asserted mid-window SHALL abort the job; no tag_vld or done is issued afterwards until a new start.

Verification
REQ-029 H=W=3, S=1, base=0x100, res_rdy=1 -> 9 reads 0x100,101,102,103,104,105,106,107,108; one tag (0,0); done with it.
REQ-030 H=W=5, S=2, base=0 -> 4 windows back-to-back (36 consecutive rd_en); window (1,1) first addr 12; tags (0,0),(0,1),(1,0),(1,1).
REQ-031 H=4, W=5, S=1, res_rdy low 20 cycles after window 2 -> 6 windows; rd_en gap only at window boundary, never inside 9-read burst.
REQ-032 cfg_w=2 or cfg_stride=0 -> no rd_en; done=1 and cfg_err=1 one cycle after start; busy=0.
REQ-033 start pulsed again mid-job with different cfg -> ignored; job completes with original cfg.
REQ-034 rst_n low during 5th read of window 2 -> all outputs 0 immediately; no tag/done until next start, which runs normally.
